// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port synchronous RAM between the instruction-fetch (IF)
// read port and the load/store (LS) read/write port. Grants are round-robin
// when both ports request at once. LS can lock the port across several
// accesses for atomic read-modify-write sequences.
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   if_req/if_addr        IF read request, held until if_gnt
//   if_gnt                IF request accepted this cycle
//   if_rvalid/if_rdata    IF read response, one cycle after grant
//   ls_req/ls_we/ls_lock/ls_addr/ls_wdata
//                         LS request, held until ls_gnt
//   ls_gnt                LS request accepted this cycle
//   ls_rvalid/ls_rdata    LS read response, one cycle after a read grant
//   mem_en/mem_we/mem_addr/mem_wdata
//                         RAM command port, driven in the grant cycle
//   mem_rdata             RAM read data, valid the cycle after a read
module mem_port_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_BITS  = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [ADDR_BITS-1:0]  if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  ls_req,
    input  logic                  ls_we,
    input  logic                  ls_lock,
    input  logic [ADDR_BITS-1:0]  ls_addr,
    input  logic [DATA_WIDTH-1:0] ls_wdata,
    output logic                  ls_gnt,
    output logic                  ls_rvalid,
    output logic [DATA_WIDTH-1:0] ls_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_BITS-1:0]  mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic {
        ST_OPEN   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_LS   = 2'd2
    } owner_t;

    state_t r_state;
    state_t w_state_next;
    logic   r_last_gnt;       // 0 = IF granted last, 1 = LS granted last
    logic   w_last_gnt_next;
    owner_t r_rd_owner;       // who receives the data returning this cycle
    owner_t w_rd_owner_next;

    logic   w_if_gnt;
    logic   w_ls_gnt;

    // State registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_OPEN;
            r_last_gnt <= 1'b0;
            r_rd_owner <= OWN_NONE;
        end else begin
            r_state    <= w_state_next;
            r_last_gnt <= w_last_gnt_next;
            r_rd_owner <= w_rd_owner_next;
        end
    end

    // Grant decision and next-state logic
    always_comb begin
        w_if_gnt        = 1'b0;
        w_ls_gnt        = 1'b0;
        w_state_next    = r_state;
        w_last_gnt_next = r_last_gnt;
        w_rd_owner_next = OWN_NONE;

        // Grants are suppressed while reset is asserted so no access
        // reaches the RAM during reset.
        if (!reset) begin
            if (r_state == ST_LOCKED) begin
                w_ls_gnt = ls_req;
            end else if (if_req && ls_req) begin
                // Conflict: the port that did not win last time goes now.
                w_ls_gnt = !r_last_gnt;
                w_if_gnt = r_last_gnt;
            end else begin
                w_ls_gnt = ls_req;
                w_if_gnt = if_req;
            end
        end

        if (w_ls_gnt) begin
            w_state_next    = ls_lock ? ST_LOCKED : ST_OPEN;
            w_last_gnt_next = 1'b1;
            w_rd_owner_next = ls_we ? OWN_NONE : OWN_LS;
        end else if (w_if_gnt) begin
            w_last_gnt_next = 1'b0;
            w_rd_owner_next = OWN_IF;
        end
    end

    // Memory command mux; idle address/data are held at zero.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_ls_gnt) begin
            mem_en    = 1'b1;
            mem_we    = ls_we;
            mem_addr  = ls_addr;
            mem_wdata = ls_wdata;
        end else if (w_if_gnt) begin
            mem_en    = 1'b1;
            mem_addr  = if_addr;
        end
    end

    assign if_gnt = w_if_gnt;
    assign ls_gnt = w_ls_gnt;

    // A response pending when reset arrives is dropped immediately, not
    // just after the reset edge.
    assign if_rvalid = !reset && (r_rd_owner == OWN_IF);
    assign ls_rvalid = !reset && (r_rd_owner == OWN_LS);

    // Both ports see the RAM output; only the matching rvalid qualifies it.
    assign if_rdata = mem_rdata;
    assign ls_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [8:0]  if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        ls_req;
    logic        ls_we;
    logic        ls_lock;
    logic [8:0]  ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_gnt;
    logic        ls_rvalid;
    logic [31:0] ls_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int n_pass  = 0;
    int n_total = 0;

    logic [31:0] ram [0:511];

    mem_port_arbiter #(.DATA_WIDTH(32), .ADDR_BITS(9)) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .ls_req    (ls_req),
        .ls_we     (ls_we),
        .ls_lock   (ls_lock),
        .ls_addr   (ls_addr),
        .ls_wdata  (ls_wdata),
        .ls_gnt    (ls_gnt),
        .ls_rvalid (ls_rvalid),
        .ls_rdata  (ls_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port synchronous RAM model
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Advance to just after the next rising edge, where inputs are driven.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Move to the falling edge, where outputs are sampled.
    task automatic settle();
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) ram[i] <= 32'h0;
        ram[9'h005] <= 32'h00A00093;
        ram[9'h007] <= 32'h33334444;
        ram[9'h010] <= 32'h55556666;
        ram[9'h100] <= 32'h11112222;
        mem_rdata = 32'h0;

        // Reset with requests asserted: nothing may be granted.
        reset = 1'b1; if_req = 1'b1; if_addr = 9'h5;
        ls_req = 1'b1; ls_we = 1'b0; ls_lock = 1'b0; ls_addr = 9'h0; ls_wdata = 32'h0;
        tick(); tick();
        settle();
        $display("step: reset held");
        chk("rst_if_gnt", {31'b0, if_gnt}, 32'd0);
        chk("rst_ls_gnt", {31'b0, ls_gnt}, 32'd0);
        chk("rst_mem_en", {31'b0, mem_en}, 32'd0);
        chk("rst_rvalid", {30'b0, if_rvalid, ls_rvalid}, 32'd0);

        // Single IF read of address 5
        tick();
        reset = 1'b0; ls_req = 1'b0;
        settle();
        $display("step: IF read addr 5");
        chk("if1_gnt", {30'b0, if_gnt, ls_gnt}, 32'b10);
        chk("if1_mem_en_we", {30'b0, mem_en, mem_we}, 32'b10);
        chk("if1_mem_addr", {23'b0, mem_addr}, 32'h5);
        tick();
        if_req = 1'b0;
        settle();
        chk("if1_rvalid", {30'b0, if_rvalid, ls_rvalid}, 32'b10);
        chk("if1_rdata", if_rdata, 32'h00A00093);

        // Continuous dual requests: LS, IF, LS, IF, LS, IF
        tick();
        if_req = 1'b1; if_addr = 9'h7;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 9'h100;
        for (int i = 0; i < 6; i++) begin
            settle();
            $display("step: conflict cycle %0d", i);
            chk("rr_gnt", {30'b0, if_gnt, ls_gnt}, (i % 2 == 0) ? 32'b01 : 32'b10);
            chk("rr_mem_addr", {23'b0, mem_addr}, (i % 2 == 0) ? 32'h100 : 32'h7);
            if (i > 0) begin
                chk("rr_rvalid", {30'b0, if_rvalid, ls_rvalid}, (i % 2 == 0) ? 32'b10 : 32'b01);
                chk("rr_rdata", mem_rdata, (i % 2 == 0) ? 32'h33334444 : 32'h11112222);
            end
            tick();
        end
        if_req = 1'b0; ls_req = 1'b0;
        settle();
        chk("rr_last_rvalid", {30'b0, if_rvalid, ls_rvalid}, 32'b10);
        chk("rr_last_rdata", if_rdata, 32'h33334444);

        // LS write 0xDEADBEEF to 0x1F0 against an IF read of the same address
        tick();
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 9'h1F0; ls_wdata = 32'hDEADBEEF;
        if_req = 1'b1; if_addr = 9'h1F0;
        settle();
        $display("step: LS write 0x1F0 vs IF read");
        chk("wr_gnt", {30'b0, if_gnt, ls_gnt}, 32'b01);
        chk("wr_mem_en_we", {30'b0, mem_en, mem_we}, 32'b11);
        chk("wr_mem_addr", {23'b0, mem_addr}, 32'h1F0);
        chk("wr_mem_wdata", mem_wdata, 32'hDEADBEEF);
        tick();
        ls_req = 1'b0; ls_we = 1'b0;
        settle();
        chk("wr_if_gnt", {30'b0, if_gnt, ls_gnt}, 32'b10);
        chk("wr_no_resp", {30'b0, if_rvalid, ls_rvalid}, 32'b00);
        chk("wr_if_mem_we", {31'b0, mem_we}, 32'd0);
        tick();
        if_req = 1'b0;
        settle();
        chk("raw_rvalid", {30'b0, if_rvalid, ls_rvalid}, 32'b10);
        chk("raw_rdata", if_rdata, 32'hDEADBEEF);

        // Locked read-modify-write at 0x10 with IF waiting
        tick();
        ls_req = 1'b1; ls_we = 1'b0; ls_lock = 1'b1; ls_addr = 9'h10;
        if_req = 1'b1; if_addr = 9'h10;
        settle();
        $display("step: LS locked read 0x10");
        chk("lk_gnt", {30'b0, if_gnt, ls_gnt}, 32'b01);
        tick();
        ls_req = 1'b0;
        settle();
        chk("lk_hold_gnt1", {30'b0, if_gnt, ls_gnt}, 32'b00);
        chk("lk_mem_en", {31'b0, mem_en}, 32'd0);
        chk("lk_rvalid", {30'b0, if_rvalid, ls_rvalid}, 32'b01);
        chk("lk_rdata", ls_rdata, 32'h55556666);
        tick();
        settle();
        chk("lk_hold_gnt2", {30'b0, if_gnt, ls_gnt}, 32'b00);
        tick();
        ls_req = 1'b1; ls_we = 1'b1; ls_lock = 1'b0; ls_wdata = 32'h0BADF00D;
        settle();
        $display("step: LS unlocking write 0x10");
        chk("ul_gnt", {30'b0, if_gnt, ls_gnt}, 32'b01);
        chk("ul_mem_we", {31'b0, mem_we}, 32'd1);
        tick();
        ls_req = 1'b0; ls_we = 1'b0;
        settle();
        chk("ul_if_gnt", {30'b0, if_gnt, ls_gnt}, 32'b10);
        tick();
        if_req = 1'b0;
        settle();
        chk("ul_rvalid", {30'b0, if_rvalid, ls_rvalid}, 32'b10);
        chk("ul_rdata", if_rdata, 32'h0BADF00D);

        // Reset during a locked read's response cycle
        tick();
        ls_req = 1'b1; ls_we = 1'b0; ls_lock = 1'b1; ls_addr = 9'h100;
        if_req = 1'b1; if_addr = 9'h7;
        settle();
        $display("step: locked read then reset");
        chk("mr_gnt", {30'b0, if_gnt, ls_gnt}, 32'b01);
        tick();
        reset = 1'b1;
        settle();
        chk("mr_rst_rvalid", {30'b0, if_rvalid, ls_rvalid}, 32'b00);
        chk("mr_rst_gnt", {30'b0, if_gnt, ls_gnt}, 32'b00);
        chk("mr_rst_mem_en", {31'b0, mem_en}, 32'd0);
        tick();
        reset = 1'b0; ls_lock = 1'b0;
        settle();
        chk("mr_post_gnt", {30'b0, if_gnt, ls_gnt}, 32'b01);
        chk("mr_post_rvalid", {30'b0, if_rvalid, ls_rvalid}, 32'b00);
        tick();
        ls_req = 1'b0;
        settle();
        chk("mr_open_if_gnt", {30'b0, if_gnt, ls_gnt}, 32'b10);
        chk("mr_ls_rvalid", {30'b0, if_rvalid, ls_rvalid}, 32'b01);
        tick();
        if_req = 1'b0;
        tick();

        // Idle for 10 cycles
        for (int i = 0; i < 10; i++) begin
            settle();
            $display("step: idle cycle %0d", i);
            chk("idle", {26'b0, mem_en, mem_we, if_gnt, ls_gnt, if_rvalid, ls_rvalid}, 32'd0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter that shares the processor's single-port synchronous RAM (32-bit × 512 words) between two requesters: the instruction-fetch path (IF) and the load/store path (LS). It sits between the processor datapath and the RAM macro, turning two request/grant ports into one memory port and routing read data back to the requester that owns it. Fairness is round-robin, and LS can lock the port for atomic read-modify-write sequences.

## Interface
- DATA_WIDTH, 32, RAM word width
- ADDR_BITS, 9, RAM address width (512 words)

- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- if_req  in  1  IF read request; held with if_addr until granted
- if_addr  in  ADDR_BITS  IF word address
- if_gnt  out  1  IF request accepted this cycle
- if_rvalid  out  1  if_rdata valid
- if_rdata  out  DATA_WIDTH  IF read data
- ls_req  in  1  LS request; held with ls_we/ls_addr/ls_wdata/ls_lock until granted
- ls_we  in  1  1 = write, 0 = read
- ls_lock  in  1  keep port owned by LS after this access
- ls_addr  in  ADDR_BITS  LS word address
- ls_wdata  in  DATA_WIDTH  LS write data
- ls_gnt  out  1  LS request accepted this cycle
- ls_rvalid  out  1  ls_rdata valid (reads only)
- ls_rdata  out  DATA_WIDTH  LS read data
- mem_en  out  1  RAM access enable
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_BITS  RAM address
- mem_wdata  out  DATA_WIDTH  RAM write data
- mem_rdata  in  DATA_WIDTH  RAM read data, valid the cycle after a read enable

## Operation
- State: FSM {OPEN, LOCKED}; last_gnt register (0 = IF last, 1 = LS last); rd_owner register {NONE, IF, LS}.
- OPEN, only one request present: grant it.
- OPEN, both requests present: grant the requester not in last_gnt. After reset last_gnt = IF, so LS wins the first conflict.
- Each grant sets last_gnt to the granted requester.
- LS grant with ls_lock = 1: go OPEN→LOCKED, or stay LOCKED.
- LOCKED: only LS can be granted. if_gnt = 0 even if if_req = 1, and last_gnt is not updated by IF.
- LOCKED, LS grant with ls_lock = 0: the access completes and the FSM returns to OPEN.
- LOCKED with no ls_req: stay LOCKED and idle. There is no timeout.
- Granted cycle drives the memory port:
  - mem_en = 1.
  - mem_we = ls_we for LS, 0 for IF (IF never writes).
  - mem_addr and mem_wdata come from the granted port.
- No grant: mem_en = 0, mem_we = 0. mem_addr and mem_wdata are don't-care; hold them at 0.
- Read grant: rd_owner is set to that requester for the next cycle. A write grant or no grant sets rd_owner = NONE.
- Response cycle: if_rvalid = (rd_owner == IF), ls_rvalid = (rd_owner == LS).
- Both rdata outputs are driven combinationally from mem_rdata. Only the matching rvalid qualifies them.
- No buffering: a requester not granted simply keeps its request asserted.

## Timing
- if_gnt, ls_gnt and mem_* are combinational from requests, FSM state and last_gnt. Accept and memory access happen in the same cycle N.
- Read data: rvalid asserted in cycle N+1 for exactly one cycle. Back-to-back reads give one response per cycle.
- Write: no response. Write data lands in RAM at the edge ending cycle N.
- At most one grant per cycle; if_gnt & ls_gnt is never 1.
- Throughput: 1 access per cycle. Under continuous dual requests, grants alternate LS, IF, LS, …
- Reset (sampled high at an edge):
  - FSM = OPEN, last_gnt = IF, rd_owner = NONE.
  - Outputs while reset is high: gnt = 0, mem_en = 0, mem_we = 0, rvalid = 0.
- Reset mid-lock or mid-read: the lock is dropped and any pending response is discarded (no rvalid after reset).
- Simultaneous LS write and IF read to the same address: only the granted access occurs. A later IF read sees the written value (RAM read-after-write across cycles).

## Test plan
- Single IF: reset, then if_req with if_addr = 5 (RAM[5] = 0x00A00093) → if_gnt in cycle N, mem_en = 1, mem_addr = 5, if_rvalid = 1 and if_rdata = 0x00A00093 in N+1, ls_rvalid = 0.
- Conflict fairness: if_req and ls_req held high (LS reads addr 0x100) for 6 cycles → grants LS, IF, LS, IF, LS, IF. Each rvalid appears the cycle after its grant and never both at once.
- LS write then IF read: LS writes 0xDEADBEEF to addr 0x1F0 while IF also requests → LS granted first (after reset), mem_we = 1. IF granted next cycle with addr 0x1F0 → if_rdata = 0xDEADBEEF.
- Lock: LS reads addr 0x10 with ls_lock = 1 and if_req held → if_gnt stays 0. LS then writes addr 0x10 with ls_lock = 0, and if_gnt rises the next cycle.
- Reset mid-operation: LS locked read granted in cycle N, reset asserted in N+1 → ls_rvalid = 0 in N+1. After reset releases with both requesting, LS is granted first and the FSM is OPEN.
- Idle: no requests for 10 cycles → mem_en = 0, all gnt and rvalid = 0 throughout.
